// File: rtl/skf_chk_pkg.sv
// Shared types and constants for the Skolem-function sweep checker.
// The sweep FSM walks IDLE -> RUN -> DONE and returns to RUN on a new start.
package skf_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int NUM_X_DEF = 5;

  // Final assignment of a sweep at the default universal-input width.
  localparam logic [NUM_X_DEF-1:0] LAST_X = '1;

endpackage

// File: rtl/skf_sat_counter.sv
// Saturating up-counter with synchronous clear; it sticks at all-ones
// instead of wrapping, so a long run of failures never reads back as zero.
module skf_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of the order in which the blocks execute.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/skf_sweep_checker.sv
// Drives every universal-input assignment into a Skolem-function netlist,
// checks the spec bit each cycle and keeps the first counterexample.
module skf_sweep_checker
  import skf_chk_pkg::*;
#(
  parameter int NUM_X        = 5,
  parameter int NUM_Y        = 2,
  parameter int CNT_W        = 8,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic [NUM_X-1:0] x_o,
  input  logic [NUM_Y-1:0] y_i,
  input  logic             spec_ok_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             cex_valid,
  output logic [NUM_X-1:0] cex_x,
  output logic [NUM_Y-1:0] cex_y,
  output logic [CNT_W-1:0] fail_cnt
);

  localparam logic [NUM_X-1:0] X_LAST = {NUM_X{1'b1}};

  state_e           state_q, state_d;
  logic [NUM_X-1:0] x_q, x_d;
  logic             pass_q, pass_d;
  logic             cex_valid_q, cex_valid_d;
  logic [NUM_X-1:0] cex_x_q, cex_x_d;
  logic [NUM_Y-1:0] cex_y_q, cex_y_d;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             sample_fail;

  assign sample_fail = ~spec_ok_i;

  // NOTE: every signal assigned here gets its default first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    pass_d      = pass_q;
    cex_valid_d = cex_valid_q;
    cex_x_d     = cex_x_q;
    cex_y_d     = cex_y_q;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        // start outranks abort outside RUN; abort alone does nothing here.
        if (start) begin
          state_d     = RUN;
          x_d         = '0;
          pass_d      = 1'b0;
          cex_valid_d = 1'b0;
          cex_x_d     = '0;
          cex_y_d     = '0;
          cnt_clr     = 1'b1;
        end
      end

      RUN: begin
        if (abort) begin
          // Aborted sample is thrown away; results so far stay visible.
          state_d = IDLE;
        end else begin
          if (sample_fail) begin
            cnt_inc = 1'b1;
            if (!cex_valid_q) begin
              cex_valid_d = 1'b1;
              cex_x_d     = x_q;
              cex_y_d     = y_i;
            end
          end

          if (STOP_ON_FAIL && sample_fail) begin
            state_d = DONE;
            pass_d  = 1'b0;
          end else if (x_q == X_LAST) begin
            // cex_valid_q covers earlier failures, sample_fail this one.
            state_d = DONE;
            pass_d  = ~cex_valid_q & ~sample_fail;
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      x_q         <= '0;
      pass_q      <= 1'b0;
      cex_valid_q <= 1'b0;
      cex_x_q     <= '0;
      cex_y_q     <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      pass_q      <= pass_d;
      cex_valid_q <= cex_valid_d;
      cex_x_q     <= cex_x_d;
      cex_y_q     <= cex_y_d;
    end
  end

  skf_sat_counter #(
    .W(CNT_W)
  ) u_fail_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr_i(cnt_clr),
    .inc_i(cnt_inc),
    .cnt_o(fail_cnt)
  );

  assign x_o       = x_q;
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign pass      = pass_q;
  assign cex_valid = cex_valid_q;
  assign cex_x     = cex_x_q;
  assign cex_y     = cex_y_q;

endmodule
